// File: rtl/mips_16_run_ctrl.sv
// Load/run session controller for a mips_16 core: streams a program into instruction memory,
// releases the core from reset, and stops it on a pc stall (halt) or on cycle-budget expiry.
module mips_16_run_ctrl #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PC_WIDTH:0]      prog_len,
    input  logic [15:0]            cycle_limit,
    input  logic                   ld_valid,
    input  logic [INSTR_WIDTH-1:0] ld_data,
    output logic                   ld_ready,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_rst,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   busy,
    output logic                   done,
    output logic                   halted,
    output logic                   timeout,
    output logic [PC_WIDTH-1:0]    halt_pc,
    output logic [15:0]            cycle_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [PC_WIDTH:0] LEN_ONE   = (PC_WIDTH+1)'(1);
    localparam logic [PC_WIDTH:0] MAX_LEN   = LEN_ONE << PC_WIDTH;
    localparam logic [4:0]        STALL_LIM = 5'(STALL_LIMIT);

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH:0]   ld_cnt_q, ld_cnt_d;
    logic [PC_WIDTH:0]   len_q, len_d;
    logic [15:0]         cyc_q, cyc_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                first_q, first_d;
    logic [3:0]          stall_q, stall_d;
    logic                halted_q, halted_d;
    logic                timeout_q, timeout_d;
    logic [PC_WIDTH-1:0] halt_pc_q, halt_pc_d;

    logic        ld_hs;
    logic        pc_same;
    logic        halt_hit;
    logic        tmo_hit;
    logic [16:0] cyc_inc;
    logic [4:0]  stall_nxt;

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        len_d     = len_q;
        cyc_d     = cyc_q;
        pc_d      = pc_q;
        first_d   = first_q;
        stall_d   = stall_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        halt_pc_d = halt_pc_q;

        ld_hs     = ld_valid & ld_ready;
        cyc_inc   = {1'b0, cyc_q} + 17'd1;
        stall_nxt = {1'b0, stall_q} + 5'd1;
        // The first RUN cycle has no valid previous pc to compare against.
        pc_same   = !first_q && (pc == pc_q);
        halt_hit  = pc_same && (stall_nxt == STALL_LIM);
        tmo_hit   = (cycle_limit != 16'd0) && (cyc_inc == {1'b0, cycle_limit});

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = (prog_len != '0) ? LOAD : RUN;
                    ld_cnt_d  = '0;
                    len_d     = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                    cyc_d     = '0;
                    first_d   = 1'b1;
                    stall_d   = '0;
                    halted_d  = 1'b0;
                    timeout_d = 1'b0;
                    halt_pc_d = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d  = IDLE;
                    ld_cnt_d = '0;
                end else if (ld_hs) begin
                    ld_cnt_d = ld_cnt_q + LEN_ONE;
                    if (ld_cnt_q + LEN_ONE == len_q) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                    stall_d = '0;
                    first_d = 1'b1;
                end else begin
                    cyc_d   = (cyc_q == 16'hFFFF) ? 16'hFFFF : cyc_inc[15:0];
                    pc_d    = pc;
                    first_d = 1'b0;
                    stall_d = pc_same ? stall_nxt[3:0] : 4'd0;
                    if (halt_hit) begin
                        state_d   = DONE;
                        halted_d  = 1'b1;
                        halt_pc_d = pc;
                    end else if (tmo_hit) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        cyc_d     = cycle_limit;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ld_cnt_q  <= '0;
            len_q     <= '0;
            cyc_q     <= '0;
            pc_q      <= '0;
            first_q   <= 1'b0;
            stall_q   <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            len_q     <= len_d;
            cyc_q     <= cyc_d;
            pc_q      <= pc_d;
            first_q   <= first_d;
            stall_q   <= stall_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    // Gating with rst keeps a reset cycle in LOAD from issuing one last write.
    assign ld_ready    = (state_q == LOAD) && !rst;
    assign imem_we     = ld_valid & ld_ready;
    assign imem_addr   = ld_cnt_q[PC_WIDTH-1:0];
    assign imem_wdata  = ld_data;
    assign core_rst    = (state_q != RUN);
    assign busy        = (state_q == LOAD) || (state_q == RUN);
    assign done        = (state_q == DONE);
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mips_16_run_ctrl.sv
// Scoreboard bench for mips_16_run_ctrl: expected writes and session results are queued at
// stimulus time and popped by a negedge monitor when the DUT writes or finishes.
module tb_mips_16_run_ctrl;

    localparam int STALL = 4;

    typedef struct packed {
        logic        h;
        logic        t;
        logic [7:0]  hpc;
        logic [15:0] cc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  prog_len = '0;
    logic [15:0] cycle_limit = '0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst;
    logic [7:0]  pc = '0;
    logic        busy;
    logic        done;
    logic        halted;
    logic        timeout;
    logic [7:0]  halt_pc;
    logic [15:0] cycle_count;

    logic [23:0] exp_wr[$];
    res_t        exp_res[$];
    logic [7:0]  plan[64];
    int          checks = 0;
    int          errors = 0;
    int          runs = 0;
    int          pidx = 0;
    logic        done_prev = 1'b0;

    mips_16_run_ctrl #(
        .PC_WIDTH(8),
        .INSTR_WIDTH(16),
        .STALL_LIMIT(STALL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prog_len(prog_len),
        .cycle_limit(cycle_limit), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .pc(pc), .busy(busy), .done(done),
        .halted(halted), .timeout(timeout), .halt_pc(halt_pc), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Session outcome from the plan: halt once STALL equal pcs follow a pc, timeout at the budget.
    function automatic res_t model(input int lim);
        res_t r;
        int run_len;
        r = '0;
        run_len = 0;
        for (int k = 1; k <= 64; k++) begin
            if (k > 1 && plan[k-1] == plan[k-2]) run_len++;
            else run_len = 0;
            if (run_len == STALL) begin
                r.h = 1'b1; r.hpc = plan[k-1]; r.cc = 16'(k);
                return r;
            end
            if (lim != 0 && k == lim) begin
                r.t = 1'b1; r.cc = 16'(k);
                return r;
            end
        end
        return r;
    endfunction

    function automatic void plan_inc();
        for (int i = 0; i < 64; i++) plan[i] = 8'(i + 1);
    endfunction

    function automatic void plan_rand(input int prefix);
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        for (int i = 0; i < 64; i++) plan[i] = (i < prefix) ? 8'($urandom_range(0, 3)) : v;
    endfunction

    // pc stimulus: one plan entry per RUN cycle, restarting whenever the core is held in reset.
    initial begin
        forever begin
            tick();
            if (core_rst) pidx = 0;
            else begin
                pc = plan[pidx];
                if (pidx < 63) pidx++;
            end
        end
    end

    // Monitor: pops expectations on each write and on each rising done.
    initial begin
        logic [23:0] e;
        res_t r;
        forever begin
            @(negedge clk);
            if (imem_we) begin
                chk("wr_expected", 32'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("imem_addr", 32'(imem_addr), 32'(e[23:16]));
                    chk("imem_wdata", 32'(imem_wdata), 32'(e[15:0]));
                end
            end
            if (!core_rst) runs++;
            if (done && !done_prev) begin
                chk("res_expected", 32'(exp_res.size() > 0), 1);
                if (exp_res.size() > 0) begin
                    r = exp_res.pop_front();
                    chk("halted", 32'(halted), 32'(r.h));
                    chk("timeout", 32'(timeout), 32'(r.t));
                    chk("halt_pc", 32'(halt_pc), 32'(r.hpc));
                    chk("cycle_count", 32'(cycle_count), 32'(r.cc));
                    chk("run_cycles", 32'(runs), 32'(r.cc));
                end
                runs = 0;
            end
            if (!busy && !done) runs = 0;
            done_prev = done;
        end
    end

    task automatic do_start(input int len, input int lim);
        prog_len = 9'(len);
        cycle_limit = 16'(lim);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_words(input int n, input bit fixed);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            if (!fixed) begin
                ld_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            d = fixed ? 16'hA001 + 16'(i) : 16'($urandom);
            ld_valid = 1'b1;
            ld_data = d;
            exp_wr.push_back({8'(i), d});
            tick();
        end
        ld_valid = 1'b0;
        chk("run_after_load", 32'(core_rst), 0);
        chk("busy_after_load", 32'(busy), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 1);
        chk("done_core_rst", 32'(core_rst), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_ld_ready", 32'(ld_ready), 0);
    endtask

    task automatic session(input int len, input int lim, input bit fixed, input bit chk_clr);
        exp_res.push_back(model(lim));
        do_start(len, lim);
        if (chk_clr) begin
            chk("restart_done", 32'(done), 0);
            chk("restart_halted", 32'(halted), 0);
            chk("restart_timeout", 32'(timeout), 0);
            chk("restart_cycles", 32'(cycle_count), 0);
            chk("restart_halt_pc", 32'(halt_pc), 0);
        end
        if (len != 0) load_words((len > 256) ? 256 : len, fixed);
        wait_done();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_core_rst"}, 32'(core_rst), 1);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 0);
        chk({tag, "_imem_we"}, 32'(imem_we), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_halt_pc"}, 32'(halt_pc), 0);
        chk({tag, "_cycles"}, 32'(cycle_count), 0);
    endtask

    initial begin
        plan_inc();
        repeat (2) tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // Fixed three-word load, then a short budgeted run.
        session(3, 5, 1'b1, 1'b0);
        // No load, pc increments, budget of 10.
        plan_inc();
        session(0, 10, 1'b0, 1'b1);
        // pc stuck at 0x05 from RUN cycle 3.
        plan[0] = 8'h01; plan[1] = 8'h02;
        for (int i = 2; i < 64; i++) plan[i] = 8'h05;
        session(0, 0, 1'b0, 1'b1);
        // Halt and budget expiry on the same edge.
        session(2, 32'(model(0).cc), 1'b0, 1'b1);

        // Abort after one of four words.
        plan_rand(10);
        do_start(4, 0);
        ld_valid = 1'b1; ld_data = 16'h1234;
        exp_wr.push_back({8'd0, 16'h1234});
        tick();
        ld_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_reset_state("abort");
        ld_valid = 1'b1;
        repeat (3) tick();
        ld_valid = 1'b0;
        plan_inc();
        session(1, 7, 1'b0, 1'b0);
        plan_rand(6);
        session(0, 0, 1'b0, 1'b1);

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            plan_rand($urandom_range(1, 30));
            session($urandom_range(0, 6),
                    ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40), 1'b0, 1'b1);
        end

        // Oversized program length loads the full 256-word memory.
        plan_inc();
        session(300, 3, 1'b0, 1'b1);

        // Reset mid-RUN.
        plan_rand(40);
        do_start(0, 0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rst_run");
        repeat (2) tick();
        chk("rst_run_stays_idle", 32'(core_rst), 1);

        // Reset mid-LOAD: later valid words must not be written.
        do_start(5, 0);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1; ld_data = 16'(16'hBEE0 + i);
            exp_wr.push_back({8'(i), 16'(16'hBEE0 + i)});
            tick();
        end
        ld_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rst_load");
        ld_valid = 1'b1;
        repeat (3) tick();
        ld_valid = 1'b0;
        repeat (2) tick();

        chk("wr_queue_drained", 32'(exp_wr.size()), 0);
        chk("res_queue_drained", 32'(exp_res.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
